// File: rtl/keccak_pkg.sv
// Shared constants and encodings for the Keccak-f[1600] round scheduler.
package keccak_pkg;

  localparam int unsigned NROUNDS = 24;
  localparam int unsigned NSLICE  = 64;
  localparam int unsigned NLANE   = 25;

  typedef enum logic [2:0] {
    PH_THETA = 3'd0,
    PH_RHO   = 3'd1,
    PH_PI    = 3'd2,
    PH_CHI   = 3'd3,
    PH_IOTA  = 3'd4
  } phaseT;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } stateT;

endpackage

// File: rtl/keccak_step_counter.sv
// Slice/lane index and round counters with phase-dependent terminal-count flags.
module keccak_step_counter
  import keccak_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       advance,
  input  phaseT      phase,
  output logic [5:0] idx,
  output logic [4:0] round,
  output logic       idxLast,
  output logic       roundLast
);

  // pi and iota are single-step phases, so they are always at their last index.
  always_comb begin
    idxLast = 1'b1;
    case (phase)
      PH_THETA, PH_CHI: idxLast = (idx == 6'(NSLICE - 1));
      PH_RHO:           idxLast = (idx == 6'(NLANE - 1));
      default:          idxLast = 1'b1;
    endcase
  end

  assign roundLast = (round == 5'(NROUNDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= '0;
      round <= '0;
    end else if (clear) begin
      idx   <= '0;
      round <= '0;
    end else if (advance) begin
      // Last round holds its value so the final round index stays visible until the next start.
      if (phase == PH_IOTA) begin
        if (!roundLast) round <= round + 5'd1;
      end else if (phase != PH_PI) begin
        idx <= idxLast ? '0 : idx + 6'd1;
      end
    end
  end

endmodule

// File: rtl/keccak_round_scheduler.sv
// Sequences theta/rho/pi/chi/iota step launches over 24 rounds of Keccak-f[1600].
module keccak_round_scheduler
  import keccak_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step_ack,
  output logic [4:0] step_go,
  output logic [2:0] phase,
  output logic [5:0] idx,
  output logic [4:0] round,
  output logic       busy,
  output logic       done
);

  stateT state, stateNext;
  phaseT phaseQ, phaseNext;
  logic  cntClear, cntAdvance, idxLast, roundLast;

  keccak_step_counter uCounter (
    .clk       (clk),
    .rst       (rst),
    .clear     (cntClear),
    .advance   (cntAdvance),
    .phase     (phaseQ),
    .idx       (idx),
    .round     (round),
    .idxLast   (idxLast),
    .roundLast (roundLast)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      phaseQ <= PH_THETA;
    end else begin
      state  <= stateNext;
      phaseQ <= phaseNext;
    end
  end

  always_comb begin
    stateNext  = state;
    phaseNext  = phaseQ;
    cntClear   = 1'b0;
    cntAdvance = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          stateNext = ST_ISSUE;
          phaseNext = PH_THETA;
          cntClear  = 1'b1;
        end
      end
      ST_ISSUE: stateNext = ST_WAIT;
      ST_WAIT: begin
        if (step_ack) begin
          cntAdvance = 1'b1;
          stateNext  = ST_ISSUE;
          case (phaseQ)
            PH_THETA: if (idxLast) phaseNext = PH_RHO;
            PH_RHO:   if (idxLast) phaseNext = PH_PI;
            PH_PI:    phaseNext = PH_CHI;
            PH_CHI:   if (idxLast) phaseNext = PH_IOTA;
            PH_IOTA: begin
              phaseNext = PH_THETA;
              if (roundLast) stateNext = ST_FINISH;
            end
            default:  phaseNext = PH_THETA;
          endcase
        end
      end
      ST_FINISH: stateNext = ST_IDLE;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    step_go = '0;
    if (state == ST_ISSUE) step_go = 5'b00001 << phaseQ;
    busy  = (state == ST_ISSUE) || (state == ST_WAIT);
    done  = (state == ST_FINISH);
    phase = phaseQ;
  end

endmodule

// File: doc/keccak_round_scheduler.md
Name: keccak_round_scheduler

Overview:
- Sequences one full Keccak-f[1600] permutation over the existing step units: column parity (theta), lane rotate (rho), permutation (pi), revaluate (chi) and add-RC (iota).
- Issues one-hot step launches with the slice/lane index and round index, waits for each unit's acknowledge, and runs 24 rounds.
- Sits between the top-level Controller start/done handshake and the Datapath step-unit init/finish signals.

Parameters:
- NROUNDS, 24, rounds per permutation
- NSLICE, 64, slices per theta/chi pass (lane width)
- NLANE, 25, lanes per rho pass

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request permutation; sampled only in IDLE
- step_ack  in  1  acknowledge from the currently launched unit (finishLane-style)
- step_go  out  5  one-hot launch pulse; bit0 theta, bit1 rho, bit2 pi, bit3 chi, bit4 iota
- phase  out  3  current phase code 0..4 (same order as step_go)
- idx  out  6  slice index (theta/chi, 0..63) or lane index (rho, 0..24); 0 for pi/iota
- round  out  5  current round 0..23; feeds add-RC constant select
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the permutation completes

Behaviour:
- Reset (rst low, any time, including mid-permutation): state=IDLE, phase=0, idx=0, round=0, step_go=0, busy=0, done=0. No pending ack is remembered.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE: start=1 -> ISSUE with phase=0, idx=0, round=0, busy=1. start=0 -> stay.
- ISSUE: step_go[phase]=1 for exactly this cycle -> WAIT. A step_ack in this cycle is ignored; units must ack no earlier than the cycle after go.
- WAIT: step_go=0. Hold phase, idx and round stable until step_ack=1, then advance:
  - theta/chi: idx<NSLICE-1 -> idx+1, ISSUE; else idx=0, phase+1, ISSUE.
  - rho: idx<NLANE-1 -> idx+1, ISSUE; else idx=0, phase=2, ISSUE.
  - pi: phase=3, ISSUE.
  - iota: round<NROUNDS-1 -> round+1, phase=0, ISSUE; else FINISH.
- FINISH: done=1 for one cycle, busy=0 -> IDLE. round keeps 23 until the next start; idx and phase return to 0.
- start while busy (ISSUE/WAIT/FINISH) is ignored, with no queueing. start held high across FINISH launches a new permutation from IDLE in the following cycle.
- Steps per round: 64+25+1+64+1=155; steps total: 3720.
- With step_ack exactly one cycle after every go:
  - each step takes 2 cycles;
  - start sampled in cycle 0 gives the first go in cycle 1;
  - the last ack falls in cycle 7440;
  - done=1 in cycle 7441.
- Stall: WAIT may last any number of cycles. There is no timeout; outputs stay stable while waiting.
- step_ack in IDLE or FINISH is ignored.
- Counter widths: idx 6 bits, round 5 bits. They wrap only through the explicit compares above, never by overflow.

Decomposition:
- Shared package keccak_pkg:
  - phase codes PH_THETA=0, PH_RHO=1, PH_PI=2, PH_CHI=3, PH_IOTA=4;
  - NROUNDS, NSLICE, NLANE constants;
  - state encoding for the scheduler.
- One sub-module, keccak_step_counter: the idx/round counter pair with its terminal-count flags (idx_last depends on phase). The FSM stays in the top module.

Test Plan:
- Reset then start=1 for one cycle, step_ack=1 the cycle after every go -> step_go=5'b00001 in cycle 1 with idx=0, round=0; done pulse in cycle 7441; busy high in cycles 1..7440.
- Count launches over one full permutation -> 1536 theta, 600 rho, 24 pi, 1536 chi, 24 iota. Every rho idx lies in 0..24, every slice idx in 0..63, round goes 0..23 in order.
- Random ack delay of 1..7 cycles -> phase, idx and round stay stable through every WAIT; exactly one step_go bit per ISSUE; total go count 3720.
- Pulse start during round 5 WAIT, and step_ack during an ISSUE cycle -> no restart; the ack is not counted and the sequence is unchanged (step 5*155+10 still awaits its own ack).
- Drive rst low asynchronously mid-cycle in round 12 chi, idx=30 -> all outputs 0 immediately. After release, start gives the first go at theta, idx=0, round=0.
- Hold start high continuously -> back-to-back permutations with one IDLE cycle between the done pulse and the next ISSUE.
